// File: rtl/alu_arbiter.sv
// Round-robin arbiter that lets NREQ requesters share one external combinational ALU.
// The granted requester's operands go out to the ALU; the result lands in a one-entry response register.
module alu_arbiter #(
  parameter  int WIDTH = 32,
  parameter  int NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*3-1:0]     req_op,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic [2:0]            alu_op,
  input  logic [WIDTH-1:0]      alu_result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_result
);

  // One extra bit so ptr+k never overflows before the modulo wrap.
  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  logic [IDW-1:0]   ptr_q, ptr_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;

  logic             can_issue_s;
  logic             grant_valid_s;
  logic [IDW-1:0]   grant_id_s;
  logic [IDW:0]     cand_s;
  logic [IDW:0]     ptr_inc_s;

  // Round-robin search from ptr; no grant during reset or while a held response is stalled.
  always_comb begin
    can_issue_s   = !rst && (!rsp_valid_q || rsp_ready);
    grant_valid_s = 1'b0;
    grant_id_s    = '0;
    cand_s        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s = {1'b0, ptr_q} + (IDW+1)'(k);
      cand_s = (cand_s >= NREQ_W) ? (cand_s - NREQ_W) : cand_s;
      if (can_issue_s && !grant_valid_s && req_valid[cand_s[IDW-1:0]]) begin
        grant_valid_s = 1'b1;
        grant_id_s    = cand_s[IDW-1:0];
      end else begin
        grant_id_s    = grant_id_s;
      end
    end
  end

  // One-hot accept and ALU operand mux; everything is zero when nothing is granted.
  always_comb begin
    req_ready = '0;
    alu_a     = '0;
    alu_b     = '0;
    alu_op    = 3'b000;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_valid_s && (grant_id_s == IDW'(i))) begin
        req_ready[i] = 1'b1;
        alu_a        = req_a[i*WIDTH +: WIDTH];
        alu_b        = req_b[i*WIDTH +: WIDTH];
        alu_op       = req_op[i*3 +: 3];
      end else begin
        req_ready[i] = 1'b0;
      end
    end
  end

  // Response register and pointer update; a grant wins over a plain drain so throughput is one per cycle.
  always_comb begin
    ptr_inc_s    = {1'b0, grant_id_s} + {{IDW{1'b0}}, 1'b1};
    ptr_d        = ptr_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    if (grant_valid_s) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = grant_id_s;
      rsp_result_d = alu_result;
      ptr_d        = (ptr_inc_s == NREQ_W) ? '0 : ptr_inc_s[IDW-1:0];
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d  = 1'b0;
    end else begin
      rsp_valid_d  = rsp_valid_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
    end else begin
      ptr_q        <= ptr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural shared ALU attached.
module tb_alu_arbiter;

  localparam int WIDTH = 32;
  localparam int NREQ  = 4;

  logic              clk;
  logic              rst;
  logic [3:0]        req_valid;
  logic [3:0]        req_ready;
  logic [127:0]      req_a;
  logic [127:0]      req_b;
  logic [11:0]       req_op;
  logic [31:0]       alu_a;
  logic [31:0]       alu_b;
  logic [2:0]        alu_op;
  logic [31:0]       alu_result;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [31:0]       rsp_result;

  int err_cnt = 0;
  int chk_cnt = 0;

  alu_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU outside the arbiter.
  always_comb begin
    case (alu_op)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_a - alu_b;
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      3'b100:  alu_result = alu_a ^ alu_b;
      3'b101:  alu_result = alu_a << alu_b[4:0];
      3'b110:  alu_result = $signed(alu_a) >>> alu_b[4:0];
      3'b111:  alu_result = {31'd0, ($signed(alu_a) < $signed(alu_b))};
      default: alu_result = 32'd0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[i*3 +: 3]  = op;
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int          fair_seq [5] = '{0, 1, 2, 3, 0};
  logic [2:0]  op_vec   [3] = '{3'b111, 3'b110, 3'b001};
  logic [31:0] a_vec    [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFF8, 32'd3};
  logic [31:0] b_vec    [3] = '{32'd1, 32'd1, 32'd5};
  logic [31:0] r_vec    [3] = '{32'd1, 32'hFFFF_FFFC, 32'hFFFF_FFFE};

  initial begin
    rst       = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    // Requester i computes 10*(i+1) + (i+1) = 11*(i+1).
    for (int i = 0; i < NREQ; i++) set_req(i, 3'b000, 32'(10 * (i + 1)), 32'(i + 1));

    #2;
    check("rst_req_ready", 64'(req_ready), 64'h0);
    check("rst_alu_a", 64'(alu_a), 64'h0);
    check("rst_alu_op", 64'(alu_op), 64'h0);
    tick();
    check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    check("rst_rsp_id", 64'(rsp_id), 64'h0);
    check("rst_rsp_result", 64'(rsp_result), 64'h0);

    // Single request from requester 0: 5 + 7.
    rst       = 1'b0;
    req_valid = 4'b0001;
    set_req(0, 3'b000, 32'd5, 32'd7);
    #1;
    check("single_ready", 64'(req_ready), 64'h1);
    check("single_alu_a", 64'(alu_a), 64'd5);
    check("single_alu_b", 64'(alu_b), 64'd7);
    tick();
    check("single_valid", 64'(rsp_valid), 64'h1);
    check("single_id", 64'(rsp_id), 64'h0);
    check("single_result", 64'(rsp_result), 64'd12);

    // No request: ALU operands idle at zero, held response drains.
    req_valid = 4'b0000;
    #1;
    check("idle_ready", 64'(req_ready), 64'h0);
    check("idle_alu_a", 64'(alu_a), 64'h0);
    tick();
    check("drain_valid", 64'(rsp_valid), 64'h0);

    // Grant requester 3 so ptr wraps to 0.
    set_req(0, 3'b000, 32'd10, 32'd1);
    req_valid = 4'b1000;
    #1;
    check("wrap_ready", 64'(req_ready), 64'h8);
    tick();
    check("wrap_id", 64'(rsp_id), 64'd3);
    check("wrap_result", 64'(rsp_result), 64'd44);

    // Fairness: all valid, grants rotate 0,1,2,3,0 with rsp_valid held high.
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      #1;
      check("fair_ready", 64'(req_ready), 64'h1 << fair_seq[n]);
      tick();
      check("fair_valid", 64'(rsp_valid), 64'h1);
      check("fair_id", 64'(rsp_id), 64'(fair_seq[n]));
      check("fair_result", 64'(rsp_result), 64'(11 * (fair_seq[n] + 1)));
    end

    // Backpressure for 3 cycles: nothing accepted, response frozen.
    rsp_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      #1;
      check("bp_ready", 64'(req_ready), 64'h0);
      check("bp_alu_op", 64'(alu_op), 64'h0);
      check("bp_alu_a", 64'(alu_a), 64'h0);
      tick();
      check("bp_valid", 64'(rsp_valid), 64'h1);
      check("bp_id", 64'(rsp_id), 64'h0);
      check("bp_result", 64'(rsp_result), 64'd11);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(req_ready), 64'h2);
    tick();
    check("bp_release_id", 64'(rsp_id), 64'd1);
    check("bp_release_result", 64'(rsp_result), 64'd22);

    // Skip: ptr=2 with 1010 gives 3 then 1 back to back.
    req_valid = 4'b1010;
    #1;
    check("skip_ready_a", 64'(req_ready), 64'h8);
    tick();
    check("skip_id_a", 64'(rsp_id), 64'd3);
    check("skip_result_a", 64'(rsp_result), 64'd44);
    #1;
    check("skip_ready_b", 64'(req_ready), 64'h2);
    tick();
    check("skip_valid_b", 64'(rsp_valid), 64'h1);
    check("skip_id_b", 64'(rsp_id), 64'd1);
    check("skip_result_b", 64'(rsp_result), 64'd22);

    // ALU ops via requester 2: SLT, SRA, SUB.
    req_valid = 4'b0100;
    for (int n = 0; n < 3; n++) begin
      set_req(2, op_vec[n], a_vec[n], b_vec[n]);
      #1;
      check("op_ready", 64'(req_ready), 64'h4);
      check("op_alu_op", 64'(alu_op), 64'(op_vec[n]));
      tick();
      check("op_id", 64'(rsp_id), 64'd2);
      check("op_result", 64'(rsp_result), 64'(r_vec[n]));
    end

    // Reset while rsp_valid=1 and ptr=3.
    rst       = 1'b1;
    req_valid = 4'b0110;
    #1;
    check("midrst_ready", 64'(req_ready), 64'h0);
    check("midrst_alu_b", 64'(alu_b), 64'h0);
    tick();
    check("midrst_valid", 64'(rsp_valid), 64'h0);
    check("midrst_id", 64'(rsp_id), 64'h0);
    check("midrst_result", 64'(rsp_result), 64'h0);
    rst = 1'b0;
    #1;
    check("postrst_ready", 64'(req_ready), 64'h2);
    tick();
    check("postrst_id", 64'(rsp_id), 64'd1);
    check("postrst_result", 64'(rsp_result), 64'd22);

    // Drive ptr to 3 again, reset, then 1001 must grant 0 rather than 3.
    set_req(2, 3'b000, 32'd30, 32'd3);
    req_valid = 4'b0100;
    tick();
    rst       = 1'b1;
    req_valid = 4'b0000;
    tick();
    rst       = 1'b0;
    req_valid = 4'b1001;
    #1;
    check("ptr_clear_ready", 64'(req_ready), 64'h1);
    tick();
    check("ptr_clear_id", 64'(rsp_id), 64'h0);
    check("ptr_clear_result", 64'(rsp_result), 64'd11);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand and result width in bits.
REQ-002 Parameter NREQ, default 4, SHALL set the number of requesters; legal range 2..8; ID width IDW = clog2(NREQ).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 req_valid  input  NREQ  SHALL be the per-requester request-valid flags; bit i belongs to requester i.
REQ-006 req_ready  output  NREQ  SHALL be the per-requester accept flags; at most one bit high per cycle.
REQ-007 req_a  input  NREQ*WIDTH  SHALL carry the signed operand A of each requester; slice i = bits [i*WIDTH +: WIDTH].
REQ-008 req_b  input  NREQ*WIDTH  SHALL carry the signed operand B of each requester, sliced as req_a.
REQ-009 req_op  input  NREQ*3  SHALL carry the 3-bit op of each requester.
  - Op encoding: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL by b[4:0], 110 SRA by b[4:0], 111 signed SLT.
REQ-010 alu_a, alu_b  output  WIDTH each  SHALL drive the shared ALU operands.
REQ-011 alu_op  output  3  SHALL drive the shared ALU op.
REQ-012 alu_result  input  WIDTH  SHALL be the shared ALU's combinational result.
REQ-013 rsp_valid  output  1  SHALL indicate that the response register holds a result.
REQ-014 rsp_ready  input  1  SHALL be the consumer's accept for the response.
REQ-015 rsp_id  output  IDW  SHALL be the index of the requester that owns the response.
REQ-016 rsp_result  output  WIDTH  SHALL be the registered ALU result.

Function
REQ-017 The block SHALL hold a one-entry response register (rsp_valid, rsp_id, rsp_result) and a round-robin pointer ptr (IDW bits).
REQ-018 can_issue SHALL be defined as (!rsp_valid || rsp_ready).
REQ-019 When can_issue is high, grant g SHALL be the first i with req_valid[i]=1, searching ptr, ptr+1, ... modulo NREQ.
REQ-020 req_ready[g] SHALL be high combinationally in the same cycle as the grant; all other req_ready bits SHALL be low.
REQ-021 The block SHALL NOT assert req_ready[i] unless req_valid[i] is high and can_issue is high.
REQ-022 While a grant is active, alu_a/alu_b/alu_op SHALL equal slice g of req_a/req_b/req_op in that cycle.
REQ-023 With no grant, alu_a, alu_b and alu_op SHALL be driven to 0.
REQ-024 On the edge ending a granted cycle, the block SHALL load the response register and update ptr:
  - rsp_result <= alu_result
  - rsp_id <= g
  - rsp_valid <= 1
  - ptr <= (g+1) mod NREQ
  - Latency: request accept to rsp_valid SHALL be exactly 1 cycle.
REQ-025 When rsp_valid and rsp_ready are high and there is no grant, rsp_valid SHALL clear at the next edge.
REQ-026 Drain and new grant in the same cycle SHALL both take effect, giving one result per cycle at full throughput.
REQ-027 While rsp_valid=1 and rsp_ready=0, the block SHALL:
  - hold all req_ready bits low;
  - hold rsp_id and rsp_result stable;
  - leave ptr unchanged.
REQ-028 ptr SHALL change only on a grant; requesters that are not valid SHALL be skipped with no idle cycle.
REQ-029 The block SHALL NOT compute anything itself; all arithmetic, including width and sign rules, SHALL come from the shared ALU.

Reset
REQ-030 When rst is high at an edge, the block SHALL set rsp_valid=0, rsp_id=0, rsp_result=0 and ptr=0, discarding any held response.
REQ-031 In a cycle where rst is high, req_ready SHALL be all-zero and alu_a/alu_b/alu_op SHALL be 0.
REQ-032 Arbitration SHALL resume on the first cycle after rst deasserts.

Verification
REQ-033 Single request: req_valid=0001, req_op[0]=000, a=5, b=7, rsp_ready=1 -> req_ready=0001 that cycle; next cycle rsp_valid=1, rsp_id=0, rsp_result=12.
REQ-034 Fairness: req_valid=1111 held, rsp_ready=1 -> grants on consecutive cycles are 0,1,2,3,0, and rsp_valid stays 1 from cycle 1 on.
REQ-035 Backpressure: rsp_valid=1, rsp_ready=0 for 3 cycles with req_valid=1111 -> req_ready=0000 and rsp_result stable for all 3 cycles; raising rsp_ready -> the grant issues in that same cycle to ptr.
REQ-036 Skip: ptr=2, req_valid=1010 -> grant 3, then grant 1; no idle cycle between them.
REQ-037 Ops through the shared ALU:
  - SLT, a=-1, b=1 -> rsp_result=1.
  - SRA, a=0xFFFFFFF8, b=1 -> rsp_result=0xFFFFFFFC.
  - SUB, a=3, b=5 -> rsp_result=0xFFFFFFFE.
REQ-038 Reset mid-stream: rst=1 for one cycle while rsp_valid=1 and ptr=3 -> next cycle rsp_valid=0 and ptr=0; with req_valid=0110 the first grant after reset is 1.
